// File: rtl/burst_chopper_pkg.sv
// Shared types and helpers for the burst chopper: FSM state encoding and
// the three-way minimum used to size each command.
package burst_chopper_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    ISSUE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Wide enough for LENGTH_WIDTH+1 and 2^BOUNDARY_LOG2 at any sane setting
  localparam int MIN_W = 64;

  function automatic logic [MIN_W-1:0] min3(input logic [MIN_W-1:0] a,
                                            input logic [MIN_W-1:0] b,
                                            input logic [MIN_W-1:0] c);
    logic [MIN_W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage

// File: rtl/burst_chopper_len_calc.sv
// Combinational command sizing: min(remaining, block, bytes to next boundary).
module burst_chopper_len_calc
  import burst_chopper_pkg::*;
#(
  parameter int LENGTH_WIDTH  = 32,
  parameter int BLOCK_WIDTH   = 24,
  parameter int BOUNDARY_LOG2 = 12,
  parameter int LSB_W         = (BOUNDARY_LOG2 > 0) ? BOUNDARY_LOG2 : 1
) (
  input  logic [LSB_W-1:0]        addr_lsb,
  input  logic [LENGTH_WIDTH-1:0] remain,
  input  logic [BLOCK_WIDTH-1:0]  blk,
  output logic [LENGTH_WIDTH:0]   len
);

  logic [MIN_W-1:0] bnd;

  always_comb begin
    // A zero boundary exponent means no splitting: the boundary term never wins
    if (BOUNDARY_LOG2 == 0) bnd = '1;
    else bnd = (MIN_W'(1) << BOUNDARY_LOG2) - MIN_W'(addr_lsb);
    len = (LENGTH_WIDTH + 1)'(min3(MIN_W'(remain), MIN_W'(blk), bnd));
  end

endmodule

// File: rtl/burst_chopper.sv
// Splits a (base, length, block size) descriptor into boundary-safe commands
// over a valid/ready interface, with sticky abort and done/error reporting.
module burst_chopper
  import burst_chopper_pkg::*;
#(
  parameter int ADDR_WIDTH    = 64,
  parameter int LENGTH_WIDTH  = 32,
  parameter int BLOCK_WIDTH   = 24,
  parameter int BOUNDARY_LOG2 = 12
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_WIDTH-1:0]   base_address,
  input  logic [LENGTH_WIDTH-1:0] transfer_length,
  input  logic [BLOCK_WIDTH-1:0]  block_size,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [ADDR_WIDTH-1:0]   cmd_address,
  output logic [BLOCK_WIDTH-1:0]  cmd_length,
  output logic                    cmd_last
);

  localparam int LSB_W = (BOUNDARY_LOG2 > 0) ? BOUNDARY_LOG2 : 1;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LENGTH_WIDTH-1:0] remain_q;
  logic [BLOCK_WIDTH-1:0]  blk_q;
  logic                    abort_q;
  logic                    zblk_q;
  logic [LENGTH_WIDTH:0]   len;

  burst_chopper_len_calc #(
    .LENGTH_WIDTH (LENGTH_WIDTH),
    .BLOCK_WIDTH  (BLOCK_WIDTH),
    .BOUNDARY_LOG2(BOUNDARY_LOG2),
    .LSB_W        (LSB_W)
  ) u_len_calc (
    .addr_lsb(addr_q[LSB_W-1:0]),
    .remain  (remain_q),
    .blk     (blk_q),
    .len     (len)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_last    <= 1'b0;
      cmd_address <= '0;
      cmd_length  <= '0;
      addr_q      <= '0;
      remain_q    <= '0;
      blk_q       <= '0;
      abort_q     <= 1'b0;
      zblk_q      <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (state != IDLE) abort_q <= abort_q | abort;
      case (state)
        IDLE: begin
          if (start) begin
            addr_q   <= base_address;
            remain_q <= transfer_length;
            blk_q    <= block_size;
            abort_q  <= abort;
            zblk_q   <= (block_size == '0);
            busy     <= 1'b1;
            state    <= (transfer_length == '0 || block_size == '0) ? FINISH : CALC;
          end
        end
        CALC: begin
          cmd_address <= addr_q;
          cmd_length  <= len[BLOCK_WIDTH-1:0];
          cmd_last    <= (len == {1'b0, remain_q});
          cmd_valid   <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          if (cmd_ready) begin
            addr_q    <= addr_q + ADDR_WIDTH'(cmd_length);
            remain_q  <= remain_q - LENGTH_WIDTH'(cmd_length);
            cmd_valid <= 1'b0;
            // An abort seen on the handshake cycle already blocks the next command
            state     <= (cmd_last || abort_q || abort) ? FINISH : CALC;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          error <= abort_q | zblk_q;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_chopper.sv
// Randomized bench for burst_chopper against an arithmetic model of the command split.
module tb_burst_chopper;

  logic        clk = 1'b0;
  logic        reset_n, start, abort, cmd_ready;
  logic [63:0] base_address;
  logic [31:0] transfer_length;
  logic [23:0] block_size;
  logic        busy, done, error, cmd_valid, cmd_last;
  logic [63:0] cmd_address;
  logic [23:0] cmd_length;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  burst_chopper dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .base_address   (base_address),
    .transfer_length(transfer_length),
    .block_size     (block_size),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_address    (cmd_address),
    .cmd_length     (cmd_length),
    .cmd_last       (cmd_last)
  );

  logic [63:0] obs_addr[$];
  logic [23:0] obs_len[$];
  bit          obs_last[$];
  logic [63:0] exp_addr[$];
  logic [23:0] exp_len[$];
  bit          exp_last[$];
  int unstable, done_cnt, done_cyc;
  bit err_v, timed_out, busy_first, busy_at_done, valid_seen;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: peel off min(remaining, block, bytes to next 4 KiB line) until empty
  function automatic void build_model(input logic [63:0] base, input logic [31:0] len,
                                      input logic [23:0] blk);
    longint unsigned addr, rem, c, bnd;
    exp_addr.delete(); exp_len.delete(); exp_last.delete();
    if (blk == 0) return;
    addr = base;
    rem  = 64'(len);
    while (rem > 0) begin
      bnd = 4096 - (addr % 4096);
      c = rem;
      if (64'(blk) < c) c = 64'(blk);
      if (bnd < c) c = bnd;
      exp_addr.push_back(addr);
      exp_len.push_back(24'(c));
      exp_last.push_back(c == rem);
      addr += c;
      rem  -= c;
    end
  endfunction

  task automatic run_xfer(input logic [63:0] base, input logic [31:0] len, input logic [23:0] blk,
                          input int ready_pct, input int abort_idx, input bit noise);
    bit          hold_prev;
    logic [63:0] pa;
    logic [23:0] pl;
    bit          plast;
    int          hold;
    obs_addr.delete(); obs_len.delete(); obs_last.delete();
    unstable = 0; done_cnt = 0; done_cyc = -1; err_v = 0; timed_out = 1;
    valid_seen = 0; busy_at_done = 1; hold = 0; hold_prev = 0;
    pa = '0; pl = '0; plast = 0;
    base_address = base; transfer_length = len; block_size = blk; start = 1'b1;
    tick();
    start = 1'b0;
    base_address = {$urandom, $urandom};
    transfer_length = $urandom;
    block_size = 24'($urandom);
    busy_first = busy;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (hold_prev && !(cmd_valid && cmd_address == pa && cmd_length == pl && cmd_last == plast))
        unstable++;
      if (cmd_valid) valid_seen = 1;
      if (done) begin
        done_cnt++; done_cyc = cyc; err_v = error; busy_at_done = busy; timed_out = 0;
        break;
      end
      abort = 1'b0;
      start = 1'b0;
      if (noise && cyc == 3) begin
        start = 1'b1; base_address = 64'hdead_0000; transfer_length = 32'd64; block_size = 24'd8;
      end
      if (cmd_valid && obs_addr.size() == abort_idx && hold < 2) begin
        cmd_ready = 1'b0;
        abort = (hold == 0);
        hold++;
      end else begin
        cmd_ready = ($urandom_range(99) < ready_pct);
      end
      if (cmd_valid && cmd_ready) begin
        obs_addr.push_back(cmd_address); obs_len.push_back(cmd_length); obs_last.push_back(cmd_last);
      end
      hold_prev = cmd_valid && !cmd_ready;
      pa = cmd_address; pl = cmd_length; plast = cmd_last;
      tick();
    end
    cmd_ready = 1'b0; abort = 1'b0; start = 1'b0;
    tick();
    if (done) done_cnt++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; cmd_ready = 1'b0;
    base_address = '0; transfer_length = '0; block_size = '0;
    tick(); tick();
    checks++; if ({busy, done, error, cmd_valid, cmd_last} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b want=00000", {busy, done, error, cmd_valid, cmd_last});
    end
    checks++; if (cmd_address !== 64'h0 || cmd_length !== 24'h0) begin
      failures++; $display("FAIL reset_cmd got=%h/%h want=0/0", cmd_address, cmd_length);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_split();
    build_model(64'h1000, 32'd1000, 24'd256);
    run_xfer(64'h1000, 32'd1000, 24'd256, 100, -1, 0);
    checks++; if (obs_addr.size() != 4) begin
      failures++; $display("FAIL basic_count got=%0d want=4", obs_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_len[i] !== exp_len[i] || obs_last[i] !== exp_last[i]) begin
        failures++;
        $display("FAIL basic_cmd%0d got=%h/%0d/%0d want=%h/%0d/%0d", i, obs_addr[i], obs_len[i],
                 obs_last[i], exp_addr[i], exp_len[i], exp_last[i]);
      end
    end
    checks++; if (obs_len.size() == 4 && (obs_addr[3] !== 64'h1300 || obs_len[3] !== 24'd232)) begin
      failures++; $display("FAIL basic_tail got=%h/%0d want=1300/232", obs_addr[3], obs_len[3]);
    end
    checks++; if (busy_first !== 1'b1 || busy_at_done !== 1'b0) begin
      failures++; $display("FAIL basic_busy got=%b%b want=10", busy_first, busy_at_done);
    end
    checks++; if (done_cnt != 1 || err_v !== 1'b0 || timed_out) begin
      failures++; $display("FAIL basic_done got=cnt%0d err%b to%b want=cnt1 err0 to0", done_cnt, err_v, timed_out);
    end
    checks++; if (done_cyc != 9) begin
      failures++; $display("FAIL basic_latency got=%0d want=9", done_cyc);
    end
  endtask

  task automatic test_boundary();
    build_model(64'h0F80, 32'd512, 24'd256);
    run_xfer(64'h0F80, 32'd512, 24'd256, 100, -1, 0);
    checks++; if (obs_addr.size() != 3 || exp_addr.size() != 3) begin
      failures++; $display("FAIL bnd_count got=%0d want=3", obs_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_len[i] !== exp_len[i] || obs_last[i] !== exp_last[i]) begin
        failures++;
        $display("FAIL bnd_cmd%0d got=%h/%0d/%0d want=%h/%0d/%0d", i, obs_addr[i], obs_len[i],
                 obs_last[i], exp_addr[i], exp_len[i], exp_last[i]);
      end
    end
    checks++; if (obs_len.size() > 0 && obs_len[0] !== 24'd128) begin
      failures++; $display("FAIL bnd_first got=%0d want=128", obs_len[0]);
    end
  endtask

  task automatic test_backpressure();
    build_model(64'h1000, 32'd1000, 24'd256);
    run_xfer(64'h1000, 32'd1000, 24'd256, 40, -1, 0);
    checks++; if (unstable != 0) begin
      failures++; $display("FAIL bp_stable got=%0d want=0", unstable);
    end
    checks++; if (obs_addr.size() != exp_addr.size()) begin
      failures++; $display("FAIL bp_count got=%0d want=%0d", obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_len[i] !== exp_len[i] || obs_last[i] !== exp_last[i]) begin
        failures++;
        $display("FAIL bp_cmd%0d got=%h/%0d want=%h/%0d", i, obs_addr[i], obs_len[i], exp_addr[i], exp_len[i]);
      end
    end
    checks++; if (done_cnt != 1 || err_v !== 1'b0) begin
      failures++; $display("FAIL bp_done got=cnt%0d err%b want=cnt1 err0", done_cnt, err_v);
    end
  endtask

  task automatic test_random();
    logic [63:0] base;
    logic [31:0] len;
    logic [23:0] blk;
    int          sum;
    for (int t = 0; t < 16; t++) begin
      if (t == 0) begin
        base = 64'hFFFF_FFFF_FFFF_FF00; len = 32'd512; blk = 24'd256;
      end else begin
        base = {$urandom, $urandom};
        if ($urandom_range(2) == 0) base[11:0] = 12'(4096 - $urandom_range(1, 64));
        len = 32'($urandom_range(1, 2000));
        blk = 24'($urandom_range(16, 700));
      end
      build_model(base, len, blk);
      run_xfer(base, len, blk, $urandom_range(30, 100), -1, 0);
      checks++; if (obs_addr.size() != exp_addr.size() || unstable != 0) begin
        failures++; $display("FAIL rnd%0d_count got=%0d unst%0d want=%0d", t, obs_addr.size(), unstable, exp_addr.size());
      end
      sum = 0;
      for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
        sum += int'(obs_len[i]);
        checks++;
        if (obs_addr[i] !== exp_addr[i] || obs_len[i] !== exp_len[i] || obs_last[i] !== exp_last[i]
            || (int'(obs_addr[i][11:0]) + int'(obs_len[i])) > 4096) begin
          failures++;
          $display("FAIL rnd%0d_cmd%0d got=%h/%0d/%0d want=%h/%0d/%0d", t, i, obs_addr[i], obs_len[i],
                   obs_last[i], exp_addr[i], exp_len[i], exp_last[i]);
        end
      end
      checks++; if (sum != int'(len) || done_cnt != 1 || err_v !== 1'b0) begin
        failures++; $display("FAIL rnd%0d_total got=sum%0d done%0d err%b want=sum%0d done1 err0", t, sum, done_cnt, err_v, len);
      end
    end
  endtask

  task automatic test_edges();
    run_xfer(64'h2000, 32'd0, 24'd256, 100, -1, 0);
    checks++; if (valid_seen || done_cnt != 1 || err_v !== 1'b0 || done_cyc != 1) begin
      failures++; $display("FAIL len0 got=v%b done%0d err%b cyc%0d want=v0 done1 err0 cyc1", valid_seen, done_cnt, err_v, done_cyc);
    end
    run_xfer(64'h2000, 32'd100, 24'd0, 100, -1, 0);
    checks++; if (valid_seen || done_cnt != 1 || err_v !== 1'b1) begin
      failures++; $display("FAIL blk0 got=v%b done%0d err%b want=v0 done1 err1", valid_seen, done_cnt, err_v);
    end
    run_xfer(64'h3000, 32'd256, 24'd256, 100, -1, 0);
    checks++; if (obs_addr.size() != 1 || obs_last.size() != 1 || obs_last[0] !== 1'b1 || obs_len[0] !== 24'd256) begin
      failures++; $display("FAIL single got=n%0d want=n1 len256 last1", obs_addr.size());
    end
  endtask

  task automatic test_abort();
    build_model(64'h1000, 32'd1000, 24'd256);
    run_xfer(64'h1000, 32'd1000, 24'd256, 100, 1, 1);
    checks++; if (obs_addr.size() != 2) begin
      failures++; $display("FAIL abort_count got=%0d want=2", obs_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < 2; i++) begin
      checks++; if (obs_addr[i] !== exp_addr[i] || obs_len[i] !== exp_len[i]) begin
        failures++; $display("FAIL abort_cmd%0d got=%h/%0d want=%h/%0d", i, obs_addr[i], obs_len[i], exp_addr[i], exp_len[i]);
      end
    end
    checks++; if (done_cnt != 1 || err_v !== 1'b1 || timed_out) begin
      failures++; $display("FAIL abort_done got=cnt%0d err%b want=cnt1 err1", done_cnt, err_v);
    end
    for (int k = 0; k < 4; k++) tick();
    checks++; if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
      failures++; $display("FAIL abort_noqueue got=busy%b valid%b want=00", busy, cmd_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit got_valid;
    base_address = 64'h1000; transfer_length = 32'd1000; block_size = 24'd256; start = 1'b1;
    cmd_ready = 1'b0;
    tick();
    start = 1'b0;
    got_valid = 0;
    for (int k = 0; k < 20 && !got_valid; k++) begin
      if (cmd_valid) got_valid = 1; else tick();
    end
    checks++; if (!got_valid) begin
      failures++; $display("FAIL rstmid_valid got=0 want=1");
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    cmd_ready = 1'b1;
    checks++; if (cmd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL rstmid_clear got=%b%b%b want=000", cmd_valid, busy, done);
    end
    valid_seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (cmd_valid || busy) valid_seen = 1;
    end
    checks++; if (valid_seen) begin
      failures++; $display("FAIL rstmid_quiet got=active want=idle");
    end
    build_model(64'h8000, 32'd300, 24'd256);
    run_xfer(64'h8000, 32'd300, 24'd256, 100, -1, 0);
    checks++; if (obs_addr.size() != 2 || obs_addr[0] !== 64'h8000 || obs_len[1] !== exp_len[1]) begin
      failures++; $display("FAIL rstmid_fresh got=n%0d want=n2 base8000", obs_addr.size());
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_split();
    test_boundary();
    test_backpressure();
    test_edges();
    test_abort();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/burst_chopper.md
Name: burst_chopper

Overview:
- Parametrised successor to the ram_controller transaction chopper.
- Latches a transfer descriptor (base address, length, block size) on a start pulse and emits a sequence of commands over a valid/ready interface.
- Each command is the minimum of the block size, the remaining bytes, and the bytes left before an address boundary, so no command crosses a 2^BOUNDARY_LOG2 boundary.
- Sits between the descriptor source and the command FIFO/master; supports abort and reports done/error.

Parameters:
- ADDR_WIDTH, 64, width of base_address and cmd_address.
- LENGTH_WIDTH, 32, width of transfer_length and the internal remaining counter.
- BLOCK_WIDTH, 24, width of block_size and cmd_length; must be <= LENGTH_WIDTH.
- BOUNDARY_LOG2, 12, no command crosses an address multiple of 2^BOUNDARY_LOG2; 0 disables boundary splitting.

Ports:
- clk, in, 1, single clock; all logic on rising edge.
- reset_n, in, 1, synchronous active-low reset.
- start, in, 1, one-cycle pulse; latches descriptor when idle.
- abort, in, 1, level; stops issuing at the next command boundary.
- base_address, in, ADDR_WIDTH, byte start address; sampled only on accepted start.
- transfer_length, in, LENGTH_WIDTH, total bytes; sampled only on accepted start.
- block_size, in, BLOCK_WIDTH, maximum bytes per command; sampled only on accepted start.
- busy, out, 1, high from accepted start until the cycle done is asserted.
- done, out, 1, one-cycle completion pulse.
- error, out, 1, valid with done: zero block_size, or aborted.
- cmd_valid, out, 1, command present.
- cmd_ready, in, 1, downstream accepts when valid & ready.
- cmd_address, out, ADDR_WIDTH, command byte address.
- cmd_length, out, BLOCK_WIDTH, command byte count, never 0.
- cmd_last, out, 1, final command of the transfer.

Behaviour:
- Reset (reset_n low at a clk edge):
  - State goes to IDLE.
  - busy, done, error, cmd_valid and cmd_last are 0; cmd_address and cmd_length are 0.
  - Reset mid-transfer discards everything; no further commands are issued.
- States: IDLE, CALC, ISSUE, FINISH.
- IDLE:
  - On start, register base_address into addr_q, transfer_length into remain_q, block_size into blk_q, and clear abort_q.
  - Next state is CALC; busy rises in the following cycle.
  - If transfer_length == 0, go to FINISH instead with error = 0 and no commands.
  - If block_size == 0, go to FINISH instead with error = 1 and no commands.
- CALC:
  - bnd = 2^BOUNDARY_LOG2 - addr_q[BOUNDARY_LOG2-1:0]; bnd is treated as infinite when BOUNDARY_LOG2 == 0.
  - len = min(remain_q, blk_q, bnd), computed at LENGTH_WIDTH+1 bits.
  - Register cmd_address = addr_q, cmd_length = len[BLOCK_WIDTH-1:0], cmd_last = (len == remain_q).
  - Assert cmd_valid and go to ISSUE.
- ISSUE:
  - cmd_valid, cmd_address, cmd_length and cmd_last stay stable until cmd_ready is high.
  - On handshake: addr_q += cmd_length (mod 2^ADDR_WIDTH, wraps silently), remain_q -= cmd_length, cmd_valid falls.
  - After handshake, go to FINISH if cmd_last or abort_q; otherwise go to CALC.
- Throughput: one command per 2 cycles while cmd_ready is held high.
- FINISH:
  - done = 1 for exactly one cycle; error = abort_q | zero-block flag.
  - busy is 0 in that same cycle; return to IDLE.
- Abort:
  - abort is sampled every busy cycle and sets sticky abort_q.
  - A command already valid is never withdrawn; it completes its handshake, then FINISH is entered.
  - If abort arrives in CALC, the pending command is still issued; no later command is issued.
  - An abort on the cycle of the cmd_last handshake gives error = 1.
- start while busy or in FINISH is ignored (no queueing). start and abort asserted together in IDLE: the start is accepted and abort_q is set.
- Invariants:
  - The sum of issued cmd_length equals transfer_length unless aborted.
  - cmd_last is asserted exactly once per non-aborted, non-empty transfer.
  - cmd_address + cmd_length never crosses a boundary when BOUNDARY_LOG2 > 0.

Decomposition:
- Package burst_chopper_pkg: state encoding constants (IDLE, CALC, ISSUE, FINISH) and a min3 length function.
- One natural sub-module, burst_chopper_len_calc: purely combinational bnd/min computation, parametrised by LENGTH_WIDTH, BLOCK_WIDTH, BOUNDARY_LOG2.
- The FSM and registers stay in burst_chopper.

Test Plan:
- Basic split: base 0x1000, length 1000, block 256, ready held high -> 4 commands (0x1000/256, 0x1100/256, 0x1200/256, 0x1300/232 last), then done with error 0.
- Boundary: base 0x0F80, length 512, block 256, BOUNDARY_LOG2 12 -> commands 0x0F80/128, 0x1000/256, 0x1100/128 last; none crosses 0x1000.
- Backpressure: basic-split stimulus with cmd_ready toggling randomly -> outputs stable while valid & !ready, same 4 commands in order, no drops or duplicates.
- Edge cases: length 0 -> done one cycle after FINISH entry, error 0, no cmd_valid. block 0 -> done, error 1, no commands. length 256 with block 256 -> a single command with cmd_last = 1.
- Abort: abort during the 2nd command's ISSUE (ready low) -> 2nd command still handshakes, no 3rd command, done with error 1; start pulses while busy are ignored.
- Reset: reset_n low mid-ISSUE -> next cycle cmd_valid, busy, done are 0; a fresh start afterwards begins at the new base address.
